image_stream_src: RTL and testbench

IMAGE_STREAM_SRC -- requirements
Module: image_stream_src

---
 rtl/image_stream_src.sv | 176 +++++++++++++++++
 tb/tb_image_stream_src.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_src.sv
// Frame-based pixel source: reads one image line at a time from a pixel memory and streams it
// out on an AXI-stream master, pacing lines with credits granted by downstream line requests.
module image_stream_src #(
   parameter int IMG_WIDTH     = 512,
   parameter int IMG_HEIGHT    = 512,
   parameter int PRELOAD_LINES = 4,
   parameter int ADDR_W        = 18
) (
   input  logic              axi_clk,
   input  logic              axi_rst,
   input  logic              i_start,
   input  logic              i_intr,
   output logic              o_mem_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [7:0]        i_mem_data,
   output logic              o_data_valid,
   output logic [7:0]        o_data,
   output logic              o_data_last,
   input  logic              i_data_ready,
   output logic              o_busy,
   output logic              o_done
);

   localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int REQ_W = $clog2(IMG_WIDTH + 1);
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   // Line 0 is started by the start pulse itself, so it spends one of the preloaded credits.
   localparam logic [3:0] PRELOAD_CRED = (PRELOAD_LINES >= 16) ? 4'd15 :
                                         (PRELOAD_LINES > 0)   ? 4'(PRELOAD_LINES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, LINE, WAIT_CREDIT, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [3:0]       credits;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic [REQ_W-1:0] req_col;
   logic             rd_pending;
   logic [1:0]       fifo_count;
   logic [7:0]       fifo_head;
   logic [7:0]       fifo_tail;
   logic             pop;
   logic             push;
   logic             last_hs;
   logic             last_row;
   logic             enter_line;
   logic             credit_avail;
   logic [2:0]       occupancy;

   assign o_data_valid = (fifo_count != 2'd0);
   assign o_data       = fifo_head;
   assign o_data_last  = o_data_valid && (col == COL_W'(IMG_WIDTH - 1));
   assign pop          = o_data_valid && i_data_ready;
   assign push         = rd_pending;
   assign last_hs      = pop && (col == COL_W'(IMG_WIDTH - 1));
   assign last_row     = (row == ROW_W'(IMG_HEIGHT - 1));
   assign occupancy    = 3'(fifo_count) + 3'(rd_pending);
   assign o_busy       = (state == LINE) || (state == WAIT_CREDIT);
   assign o_done       = (state == DONE);

   // A slot freed by this cycle's handshake may be refilled at once, which keeps full rate.
   assign o_mem_en   = (state == LINE) && (req_col < REQ_W'(IMG_WIDTH)) &&
                       ((occupancy < 3'd2) || (pop && (occupancy == 3'd2)));
   assign o_mem_addr = ADDR_W'(row) * ADDR_W'(IMG_WIDTH) + ADDR_W'(req_col);

   always_comb begin
      state_next   = state;
      enter_line   = 1'b0;
      credit_avail = (credits != 4'd0) || i_intr;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_next = LINE;
               enter_line = 1'b1;
            end
         end
         LINE: begin
            if (last_hs) begin
               if (last_row) begin
                  state_next = DONE;
               end else if (credit_avail) begin
                  state_next = LINE;
                  enter_line = 1'b1;
               end else begin
                  state_next = WAIT_CREDIT;
               end
            end
         end
         WAIT_CREDIT: begin
            if (credits != 4'd0) begin
               state_next = LINE;
               enter_line = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) state <= IDLE;
      else         state <= state_next;
   end

   // A request arriving in the same cycle a line starts pays for that line, leaving credits unchanged.
   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         credits <= 4'd0;
      end else if (state == IDLE) begin
         if (i_start) credits <= PRELOAD_CRED;
      end else if (state != DONE) begin
         if (i_intr && !enter_line) begin
            if (credits != 4'hF) credits <= credits + 4'd1;
         end else if (!i_intr && enter_line) begin
            credits <= credits - 4'd1;
         end
      end
   end

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         row     <= '0;
         col     <= '0;
         req_col <= '0;
      end else if ((state == IDLE) && i_start) begin
         row     <= '0;
         col     <= '0;
         req_col <= '0;
      end else begin
         if (o_mem_en) req_col <= req_col + 1'b1;
         if (pop) begin
            if (col == COL_W'(IMG_WIDTH - 1)) begin
               col     <= '0;
               req_col <= '0;
               if (!last_row) row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Two-entry output FIFO; a read still in flight at reset is dropped with rd_pending.
   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         rd_pending <= 1'b0;
         fifo_count <= 2'd0;
         fifo_head  <= 8'd0;
         fifo_tail  <= 8'd0;
      end else begin
         rd_pending <= o_mem_en;
         case ({push, pop})
            2'b10: begin
               if (fifo_count == 2'd0) fifo_head <= i_mem_data;
               else                    fifo_tail <= i_mem_data;
               fifo_count <= fifo_count + 2'd1;
            end
            2'b01: begin
               fifo_head  <= fifo_tail;
               fifo_count <= fifo_count - 2'd1;
            end
            2'b11: begin
               if (fifo_count == 2'd1) begin
                  fifo_head <= i_mem_data;
               end else begin
                  fifo_head <= fifo_tail;
                  fifo_tail <= i_mem_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_image_stream_src.sv
// Self-checking bench for image_stream_src on a 4x6 image with memory[a]=a: a frame-level
// pixel/address model checks every cycle, directed scenarios pin timing and corner cases.
module tb_image_stream_src;

   localparam int W     = 4;
   localparam int H     = 6;
   localparam int TOTAL = W * H;

   logic        axi_clk;
   logic        axi_rst;
   logic        i_start;
   logic        i_intr;
   logic        o_mem_en;
   logic [17:0] o_mem_addr;
   logic [7:0]  i_mem_data = 8'd0;
   logic        o_data_valid;
   logic [7:0]  o_data;
   logic        o_data_last;
   logic        i_data_ready;
   logic        o_busy;
   logic        o_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_pix = 0;
   int exp_addr = 0;
   int last_frame_px = 0;
   bit done_due = 1'b0;
   bit prev_stall = 1'b0;
   int hs_cycle[TOTAL];

   image_stream_src #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRELOAD_LINES(4), .ADDR_W(18)
   ) dut (
      .axi_clk(axi_clk), .axi_rst(axi_rst), .i_start(i_start), .i_intr(i_intr),
      .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
      .o_data_valid(o_data_valid), .o_data(o_data), .o_data_last(o_data_last),
      .i_data_ready(i_data_ready), .o_busy(o_busy), .o_done(o_done)
   );

   initial begin
      axi_clk = 1'b0;
      forever #5 axi_clk = ~axi_clk;
   end

   always @(posedge axi_clk) cyc <= cyc + 1;

   // Pixel memory with one cycle of read latency, holding memory[a] = a.
   always @(posedge axi_clk) if (o_mem_en) i_mem_data <= o_mem_addr[7:0];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Frame model: pixels and read addresses run 0..TOTAL-1 in order, done follows the last pixel.
   always @(negedge axi_clk) begin
      if (axi_rst) begin
         exp_pix    = 0;
         exp_addr   = 0;
         done_due   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) checkOutput("hold_valid", o_data_valid, 1);
         checkOutput("done_pulse", o_done, done_due);
         if (done_due) begin
            last_frame_px = exp_pix;
            exp_pix       = 0;
            exp_addr      = 0;
            done_due      = 1'b0;
         end
         if (o_mem_en) begin
            checkOutput("mem_addr", o_mem_addr, exp_addr);
            exp_addr++;
         end
         if (o_data_valid) begin
            checkOutput("pixel", o_data, exp_pix & 255);
            checkOutput("tlast", o_data_last, (exp_pix % W) == (W - 1));
            if (i_data_ready) begin
               if (exp_pix < TOTAL) hs_cycle[exp_pix] = cyc;
               exp_pix++;
               if (exp_pix == TOTAL) done_due = 1'b1;
            end
         end
         prev_stall = o_data_valid && !i_data_ready;
      end
   end

   task automatic applyStimulus(input logic start, input logic intr, input logic ready, input int cycles);
      i_start      = start;
      i_intr       = intr;
      i_data_ready = ready;
      repeat (cycles) @(posedge axi_clk);
      #1;
   endtask

   task automatic startFrame(input logic ready, output int lat);
      applyStimulus(1'b1, 1'b0, ready, 1);
      i_start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge axi_clk);
         #1;
         if (o_data_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic waitDone(input int budget, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(posedge axi_clk);
         #1;
         if (o_done) begin
            seen = 1'b1;
            break;
         end
      end
      @(negedge axi_clk);
      @(posedge axi_clk);
      #1;
   endtask

   task automatic waitPixel(input int value, input int budget, output bit found);
      found = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge axi_clk);
         if (o_data_valid && (o_data == 8'(value))) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_valid"}, o_data_valid, 0);
      checkOutput({tag, "_data"},  o_data, 0);
      checkOutput({tag, "_last"},  o_data_last, 0);
      checkOutput({tag, "_mem_en"}, o_mem_en, 0);
      checkOutput({tag, "_addr"},  o_mem_addr, 0);
      checkOutput({tag, "_busy"},  o_busy, 0);
      checkOutput({tag, "_done"},  o_done, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat;
      bit seen;
      bit found;

      axi_rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, 3);
      checkResetOutputs("reset");
      axi_rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 2);
      checkOutput("idle_no_start_busy", o_busy, 0);

      $display("[TB] full frame, two requests after line 3");
      startFrame(1'b1, lat);
      checkOutput("t1_latency", lat, 2);
      checkOutput("t1_first_pixel", o_data, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 40);
      checkOutput("t1_stall_count", exp_pix, 16);
      checkOutput("t1_stall_valid", o_data_valid, 0);
      checkOutput("t1_stall_busy", o_busy, 1);
      checkOutput("t1_no_bubble", hs_cycle[3] - hs_cycle[0], 3);
      checkOutput("t1_line_gap", (hs_cycle[4] - hs_cycle[3]) <= 4, 1);
      applyStimulus(1'b0, 1'b1, 1'b1, 2);
      i_intr = 1'b0;
      waitDone(60, seen);
      checkOutput("t1_done_seen", seen, 1);
      checkOutput("t1_frame_pixels", last_frame_px, TOTAL);
      checkOutput("t1_busy_after", o_busy, 0);

      $display("[TB] no requests, then one line at a time");
      startFrame(1'b1, lat);
      applyStimulus(1'b0, 1'b0, 1'b1, 40);
      checkOutput("t2_stall_count", exp_pix, 16);
      checkOutput("t2_stall_valid", o_data_valid, 0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 20);
      checkOutput("t2_one_line_count", exp_pix, 20);
      checkOutput("t2_one_line_valid", o_data_valid, 0);
      checkOutput("t2_one_line_busy", o_busy, 1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1);
      i_intr = 1'b0;
      waitDone(40, seen);
      checkOutput("t2_done_seen", seen, 1);
      checkOutput("t2_frame_pixels", last_frame_px, TOTAL);

      $display("[TB] request coincides with last-pixel handshake at zero credit");
      startFrame(1'b1, lat);
      waitPixel(15, 60, found);
      checkOutput("t3_pixel15_found", found, 1);
      i_intr = 1'b1;
      @(posedge axi_clk);
      #1;
      i_intr = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 10);
      checkOutput("t3_line_gap", (hs_cycle[16] - hs_cycle[15]) <= 4, 1);
      checkOutput("t3_count", exp_pix, 20);
      applyStimulus(1'b0, 1'b1, 1'b1, 1);
      i_intr = 1'b0;
      waitDone(40, seen);
      checkOutput("t3_done_seen", seen, 1);

      $display("[TB] random ready");
      startFrame(1'b1, lat);
      seen = 1'b0;
      for (int k = 0; k < 800; k++) begin
         i_data_ready = 1'($urandom_range(0, 1));
         i_intr       = ((k % 10) == 0);
         @(posedge axi_clk);
         #1;
         if (o_done) begin
            seen = 1'b1;
            break;
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 0);
      @(negedge axi_clk);
      @(posedge axi_clk);
      #1;
      checkOutput("t4_done_seen", seen, 1);
      checkOutput("t4_frame_pixels", last_frame_px, TOTAL);

      $display("[TB] reset during pixel 9");
      startFrame(1'b1, lat);
      waitPixel(9, 40, found);
      checkOutput("t5_pixel9_found", found, 1);
      #1 axi_rst = 1'b1;
      #1;
      checkResetOutputs("t5_reset");
      @(posedge axi_clk);
      @(posedge axi_clk);
      #1 axi_rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 2);
      checkOutput("t5_idle_valid", o_data_valid, 0);
      startFrame(1'b1, lat);
      checkOutput("t5_latency", lat, 2);
      checkOutput("t5_first_pixel", o_data, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 40);
      applyStimulus(1'b0, 1'b1, 1'b1, 2);
      i_intr = 1'b0;
      waitDone(60, seen);
      checkOutput("t5_done_seen", seen, 1);
      checkOutput("t5_frame_pixels", last_frame_px, TOTAL);

      $display("[TB] start ignored mid-frame, credit saturation");
      startFrame(1'b1, lat);
      applyStimulus(1'b0, 1'b0, 1'b1, 3);
      applyStimulus(1'b1, 1'b0, 1'b1, 1);
      i_start = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 40);
      checkOutput("t6_stall_count", exp_pix, 16);
      checkOutput("t6_stall_valid", o_data_valid, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 20);
      i_intr = 1'b0;
      checkOutput("t6_credits_sat", dut.credits, 15);
      checkOutput("t6_held_valid", o_data_valid, 1);
      checkOutput("t6_held_pixel", o_data, 16);
      applyStimulus(1'b0, 1'b0, 1'b1, 0);
      waitDone(60, seen);
      checkOutput("t6_done_seen", seen, 1);
      checkOutput("t6_frame_pixels", last_frame_px, TOTAL);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
